// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and
// presents pcplus4/instr/flush to the IF/ID register, absorbing stalls, redirects and memory wait states.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pcplus4,
    output logic [WIDTH-1:0] instr,
    output logic             flush,
    output logic [WIDTH-1:0] fetch_pc
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_VALID,
        S_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] br_addr;
    logic             hs;

    assign pc_inc  = pc_q + WIDTH'(4);
    assign br_addr = branch_target & ~(WIDTH'(3));
    assign hs      = imem_req & imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            pcplus4_q <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            pcplus4_q <= pcplus4_d;
            instr_q   <= instr_d;
        end
    end

    // A redirect with a request still in flight must wait for that ack, since
    // req/addr may not change before it; the target is parked in tgt_q meanwhile.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pcplus4_d = pcplus4_q;
        instr_d   = instr_q;
        if (branch_taken) begin
            if (imem_req && !imem_ack) begin
                tgt_d   = br_addr;
                state_d = S_DRAIN;
            end else begin
                pc_d    = br_addr;
                state_d = S_WAIT;
            end
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (hs) begin
                        instr_d   = imem_rdata;
                        pcplus4_d = pc_inc;
                        pc_d      = pc_inc;
                        state_d   = S_VALID;
                    end
                end
                S_VALID: begin
                    if (hs) begin
                        instr_d   = imem_rdata;
                        pcplus4_d = pc_inc;
                        pc_d      = pc_inc;
                    end else if (imem_req) begin
                        state_d = S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (hs) begin
                        pc_d    = tgt_q;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        flush    = 1'b1;
        unique case (state_q)
            S_WAIT:  imem_req = 1'b1;
            S_VALID: begin
                imem_req = ~stall;
                flush    = 1'b0;
            end
            S_DRAIN: imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
        if (reset) begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr = reset ? RESET_PC : pc_q;
    assign pcplus4   = pcplus4_q;
    assign instr     = instr_q;
    assign fetch_pc  = pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that produces the pcplus4 / instr / flush triple consumed by the IF/ID pipeline register. It owns the PC. It issues requests to instruction memory over a req/ack handshake and presents each returned instruction until decode accepts it. Stall, branch redirect and variable-latency memory are resolved here, so IF/ID sees only valid instructions or bubbles (flush=1).

Parameters:
WIDTH, 32, datapath/address width
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous active-high reset
stall  input  1  hazard unit: hold presented instruction, do not advance
branch_taken  input  1  single-cycle redirect request
branch_target  input  WIDTH  redirect address; bits [1:0] ignored (forced 0)
imem_req  output  1  memory request
imem_addr  output  WIDTH  request address
imem_ack  input  1  request complete; imem_rdata valid this cycle
imem_rdata  input  WIDTH  instruction word
pcplus4  output  WIDTH  to IF/ID pcplus4
instr  output  WIDTH  to IF/ID instr
flush  output  1  to IF/ID flush; 1 = bubble
fetch_pc  output  WIDTH  current PC (debug)

Behaviour:
- Single clock (clk). Reset is synchronous, active-high (reset). All registers update on posedge clk only.
- Reset values: pc=RESET_PC, state=S_WAIT, pcplus4=0, instr=0, flush=1, tgt_q=0. imem_req=0 while reset=1. imem_addr=RESET_PC.
- Handshake rules:
  - Once imem_req=1, both imem_req and imem_addr stay stable until imem_ack.
  - imem_ack may arrive in the same cycle as imem_req (zero-wait memory).
  - imem_ack while imem_req=0 is ignored.
  - A reset mid-request abandons it. Memory shares the same reset.
- S_WAIT:
  - imem_req=1, imem_addr=pc, flush=1.
  - On ack: instr<=rdata, pcplus4<=pc+4, pc<=pc+4, go to S_VALID.
- S_VALID:
  - flush=0. pcplus4/instr hold their registered values.
  - If stall=1: imem_req=0; pc, outputs and state hold.
  - If stall=0: imem_req=1, imem_addr=pc (next fetch).
    - Ack in the same cycle: capture as in S_WAIT and stay in S_VALID. Zero-wait memory gives 1 instruction/cycle.
    - No ack: go to S_WAIT; flush=1 until data returns.
- S_DRAIN:
  - imem_req=1, imem_addr=pc (the old, outstanding address), flush=1.
  - On ack: discard rdata, pc<=tgt_q, go to S_WAIT.
- Branch priority: reset > branch_taken > ack/stall. Applies in any state when branch_taken=1:
  - No request outstanding, or the outstanding request is acked this cycle: discard any returned data; pc<=branch_target&~3; go to S_WAIT.
  - A request is asserted this cycle without ack: tgt_q<=branch_target&~3; go to S_DRAIN. pc is unchanged until the drain completes.
  - In S_DRAIN: tgt_q is overwritten (latest branch wins).
- Branch with stall=1: branch wins, and the held instruction is dropped (flush=1 from the next cycle).
- flush is 1 in every state except S_VALID. flush=1 is registered, so IF/ID captures a bubble exactly in the cycles where no valid instruction is presented.
- Arithmetic: pc+4 wraps modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000); no error. pcplus4 carries the wrapped value.
- fetch_pc = pc register.

Test Plan:
1. Zero-wait memory (ack=req), mem[i]=0x1000+i, reset released at cycle 0. From cycle 1 on: flush=0; pcplus4 = 4, 8, 12, ...; instr = 0x1000, 0x1001, ...; one instruction per cycle.
2. Two-wait-state memory. imem_req stays high 3 cycles with addr 0. instr=mem[0] and pcplus4=4 appear the cycle after ack. flush=1 during the wait cycles.
3. stall=1 for 3 cycles while in S_VALID with pcplus4=8. imem_req=0, and pcplus4=8 / instr hold all 3 cycles. The fetch at addr 8 issues in the first cycle stall=0.
4. branch_taken with target 0x103 in S_WAIT, ack 2 cycles later with rdata=0xDEADBEEF. 0xDEADBEEF is never presented (flush stays 1). The next request goes to addr 0x100; the result is presented with pcplus4=0x104.
5. branch_taken, stall=1 and ack in the same cycle. The held instruction is dropped. Next imem_addr=target, with no drain cycle.
6. reset asserted in S_WAIT, and separately with pc=0xFFFFFFFC. After reset: flush=1, pc=RESET_PC, outputs 0. In the second case, the fetch at 0xFFFFFFFC yields pcplus4=0 and the next imem_addr=0.
